// File: rtl/parity_frame_engine.sv
// Streaming parity generator/checker: folds XOR parity over frames of up to FRAME_LEN words
// and presents even/odd parity plus a check-mode mismatch flag on a valid/ready result port.
module parity_frame_engine #(
  parameter int DATA_W    = 9,
  parameter int FRAME_LEN = 4,
  parameter int ERRCNT_W  = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               mode,
  input  logic                               odd_sel,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [DATA_W-1:0]                  in_data,
  input  logic                               in_last,
  input  logic                               in_par,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               ep,
  output logic                               op,
  output logic                               err,
  output logic [$clog2(FRAME_LEN+1)-1:0]     word_cnt,
  output logic [ERRCNT_W-1:0]                err_cnt
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t              state_q;
  logic                acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mode_q;
  logic                odd_q;
  logic                ep_q;
  logic                op_q;
  logic                err_q;
  logic [CNT_W-1:0]    wc_q;
  logic [ERRCNT_W-1:0] ec_q;
  logic                ov_q;

  logic                accept;
  logic                acc_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                mode_d;
  logic                odd_d;
  logic                close_d;
  logic                err_d;

  assign in_ready = ~rst & (state_q != RESULT);
  assign accept   = in_valid & in_ready;

  // In IDLE the incoming word starts a fresh frame, so the live mode/odd_sel
  // and a zero accumulator are used; this lets a one-word frame close at once.
  always_comb begin
    acc_d   = ((state_q == ACCUM) ? acc_q : 1'b0) ^ (^in_data);
    cnt_d   = ((state_q == ACCUM) ? cnt_q : '0) + CNT_W'(1);
    mode_d  = (state_q == IDLE) ? mode : mode_q;
    odd_d   = (state_q == IDLE) ? odd_sel : odd_q;
    close_d = in_last | (cnt_d == CNT_W'(FRAME_LEN));
    err_d   = mode_d & (in_par != (odd_d ? ~acc_d : acc_d));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      odd_q   <= 1'b0;
      ep_q    <= 1'b0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      wc_q    <= '0;
      ec_q    <= '0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            odd_q  <= odd_d;
            if (close_d) begin
              state_q <= RESULT;
              ep_q    <= acc_d;
              op_q    <= ~acc_d;
              err_q   <= err_d;
              wc_q    <= cnt_d;
              ov_q    <= 1'b1;
              if (err_d && (ec_q != '1))
                ec_q <= ec_q + ERRCNT_W'(1);
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        RESULT: begin
          if (out_ready) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            ov_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          acc_q   <= 1'b0;
          cnt_q   <= '0;
          ov_q    <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = ov_q;
  assign ep        = ep_q;
  assign op        = op_q;
  assign err       = err_q;
  assign word_cnt  = wc_q;
  assign err_cnt   = ec_q;

endmodule

// File: tb/tb_parity_frame_engine.sv
// Directed bench for parity_frame_engine: a frame model pushes expected results to a queue
// as words are accepted; results are popped and compared when out_valid is seen.
module tb_parity_frame_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic       odd_sel;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_data;
  logic       in_last;
  logic       in_par;
  logic       out_valid;
  logic       out_ready;
  logic       ep;
  logic       op;
  logic       err;
  logic [2:0] word_cnt;
  logic [7:0] err_cnt;

  parity_frame_engine #(.DATA_W(9), .FRAME_LEN(4), .ERRCNT_W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .odd_sel(odd_sel),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_par(in_par),
    .out_valid(out_valid), .out_ready(out_ready),
    .ep(ep), .op(op), .err(err), .word_cnt(word_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ep;
    logic       err;
    logic [2:0] wc;
    logic [7:0] ec;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  logic       m_acc;
  int         m_cnt;
  logic       m_mode;
  logic       m_odd;
  int         m_errcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 1'b0;
    m_cnt = 0;
    m_errcnt = 0;
    sb.delete();
  endtask

  task automatic model_accept(input logic [8:0] d, input logic last, input logic par);
    exp_t e;
    if (m_cnt == 0) begin
      m_mode = mode;
      m_odd  = odd_sel;
      m_acc  = 1'b0;
    end
    m_acc = m_acc ^ (^d);
    m_cnt++;
    if (last || m_cnt == 4) begin
      e.ep  = m_acc;
      e.err = m_mode && (par != (m_odd ? ~m_acc : m_acc));
      if (e.err && m_errcnt != 255) m_errcnt++;
      e.wc  = 3'(m_cnt);
      e.ec  = 8'(m_errcnt);
      sb.push_back(e);
      m_cnt = 0;
    end
  endtask

  task automatic send_word(input logic [8:0] d, input logic last, input logic par);
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_par   = par;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    check("accept_timeout", {31'd0, acc}, 32'd1);
    if (acc) model_accept(d, last, par);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_par   = 1'b0;
  endtask

  task automatic wait_result(input string tag, input bit immediate, input bit consume);
    int   waited;
    exp_t e;
    waited = 0;
    while (!out_valid && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    if (immediate) check({tag, "_latency"}, waited, 0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, sb.size(), 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_ep"}, {31'd0, ep}, {31'd0, e.ep});
      check({tag, "_op"}, {31'd0, op}, {31'd0, ~e.ep});
      check({tag, "_err"}, {31'd0, err}, {31'd0, e.err});
      check({tag, "_wc"}, {29'd0, word_cnt}, {29'd0, e.wc});
      check({tag, "_ec"}, {24'd0, err_cnt}, {24'd0, e.ec});
    end
    if (consume) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; odd_sel = 1'b0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; in_par = 1'b0; out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ep", {31'd0, ep}, 32'd0);
    check("rst_op", {31'd0, op}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst = 1'b0;
    #1;
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Single-word generate frame
    send_word(9'h007, 1'b1, 1'b0);
    wait_result("gen1", 1'b1, 1'b1);
    check("gen1_drop", {31'd0, out_valid}, 32'd0);
    check("gen1_hold_ep", {31'd0, ep}, 32'd1);

    // Frame closes at FRAME_LEN without in_last
    send_word(9'h007, 1'b0, 1'b0);
    send_word(9'h001, 1'b0, 1'b0);
    send_word(9'h002, 1'b0, 1'b0);
    check("gen4_not_yet", {31'd0, out_valid}, 32'd0);
    send_word(9'h006, 1'b0, 1'b0);
    wait_result("gen4", 1'b1, 1'b1);

    // Two-word frame closed early by in_last
    send_word(9'h003, 1'b0, 1'b1);
    send_word(9'h001, 1'b1, 1'b1);
    wait_result("gen2", 1'b1, 1'b1);

    // Check mode, even and odd
    mode = 1'b1; odd_sel = 1'b0;
    send_word(9'h180, 1'b1, 1'b1);
    wait_result("chk_even_bad", 1'b1, 1'b1);
    send_word(9'h180, 1'b1, 1'b0);
    wait_result("chk_even_ok", 1'b1, 1'b1);
    odd_sel = 1'b1;
    send_word(9'h1F1, 1'b1, 1'b1);
    wait_result("chk_odd_ok", 1'b1, 1'b1);
    // mode sampled on first word only: changing it mid-frame has no effect
    mode = 1'b1; odd_sel = 1'b0;
    send_word(9'h001, 1'b0, 1'b0);
    mode = 1'b0;
    send_word(9'h000, 1'b1, 1'b0);
    wait_result("chk_midmode", 1'b1, 1'b1);

    // Backpressure
    mode = 1'b0; odd_sel = 1'b0;
    out_ready = 1'b0;
    send_word(9'h007, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 9'h001; in_last = 1'b1; in_par = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_ep", {31'd0, ep}, 32'd1);
      check("bp_op", {31'd0, op}, 32'd0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    wait_result("bp", 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("bp_drop", {31'd0, out_valid}, 32'd0);
    check("bp_in_ready_after", {31'd0, in_ready}, 32'd1);
    check("bp_ep_hold", {31'd0, ep}, 32'd1);
    @(posedge clk);
    #1;
    model_accept(9'h001, 1'b1, 1'b0);
    in_valid = 1'b0; in_last = 1'b0;
    wait_result("bp_next", 1'b1, 1'b1);

    // Reset mid-frame
    send_word(9'h003, 1'b0, 1'b0);
    send_word(9'h005, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_ep", {31'd0, ep}, 32'd0);
    check("mrst_err", {31'd0, err}, 32'd0);
    check("mrst_wc", {29'd0, word_cnt}, 32'd0);
    check("mrst_ec", {24'd0, err_cnt}, 32'd0);
    rst = 1'b0;
    send_word(9'h001, 1'b1, 1'b0);
    wait_result("post_rst", 1'b1, 1'b1);

    // Error counter saturation
    mode = 1'b1; odd_sel = 1'b0;
    for (int i = 0; i < 258; i++) begin
      send_word(9'h180, 1'b1, 1'b1);
      wait_result("sat", 1'b1, 1'b1);
    end
    check("sat_final", {24'd0, err_cnt}, 32'h0FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
